// File: rtl/waveform_oscillator.sv
// Multi-waveform oscillator: a prescaled phase accumulator mapped to pulse, sawtooth
// or triangle samples, with a once-per-period sync strobe aligned to the phase-0 sample.
module waveform_oscillator #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  count_max,
    input  logic [DATA_WIDTH-1:0] duty,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  sync
);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_DATA  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  ZERO_CNT  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  ONE_CNT   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0] phase_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  wrap_r;
    logic                  sync_r;
    logic                  tick_s;

    // Triangle folds the upper half back down, so the peak and zero each appear twice.
    function automatic logic [DATA_WIDTH-1:0] wave_sample(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] ph,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [DATA_WIDTH-1:0] result;
        result = ZERO_DATA;
        case (m)
            2'd0: begin
                if (ph < d) begin
                    result = ALL_ONES;
                end else begin
                    result = ZERO_DATA;
                end
            end
            2'd1: result = ph;
            2'd2: begin
                if (ph[DATA_WIDTH-1]) begin
                    result = {~ph[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    result = {ph[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: result = ZERO_DATA;
        endcase
        return result;
    endfunction

    // Prescaler terminal detect; >= lets a lowered count_max take effect immediately.
    always_comb begin
        tick_s = 1'b0;
        if (enable && (cnt_r >= count_max)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler, phase accumulator, sample register and two-stage sync pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= ZERO_CNT;
            phase_r <= ZERO_DATA;
            data_r  <= ZERO_DATA;
            wrap_r  <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            data_r <= wave_sample(mode, phase_r, duty);
            sync_r <= wrap_r;
            wrap_r <= tick_s && (phase_r == ALL_ONES);
            if (enable) begin
                if (tick_s) begin
                    cnt_r   <= ZERO_CNT;
                    phase_r <= phase_r + ONE_DATA;
                end else begin
                    cnt_r   <= cnt_r + ONE_CNT;
                    phase_r <= phase_r;
                end
            end else begin
                cnt_r   <= cnt_r;
                phase_r <= phase_r;
            end
        end
    end

    assign data = data_r;
    assign sync = sync_r;

endmodule

// File: tb/tb_waveform_oscillator.sv
// Self-checking bench for waveform_oscillator (DATA_WIDTH=8): directed scenarios plus
// randomized stimulus, compared each cycle against an arithmetic reference model.
module tb_waveform_oscillator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] count_max = 32'd0;
    logic [7:0]  duty = 8'd0;
    logic [7:0]  data;
    logic        sync;

    int checks = 0;
    int errors = 0;

    // Reference state: prescaler count, phase index, pending wrap, expected outputs.
    longint m_cnt = 0;
    int     m_phase = 0;
    bit     m_wrap = 1'b0;
    int     m_data = 0;
    bit     m_sync = 1'b0;
    int     sync_seen = 0;

    waveform_oscillator #(.DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .count_max (count_max),
        .duty      (duty),
        .data      (data),
        .sync      (sync)
    );

    always #5 clk = ~clk;

    function automatic int ref_wave(input int m, input int ph, input int d);
        if (m == 0) return (ph < d) ? 255 : 0;
        if (m == 1) return ph;
        if (m == 2) return (ph < 128) ? 2 * ph : 2 * (255 - ph);
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_phase = 0; m_wrap = 1'b0; m_data = 0; m_sync = 1'b0;
        end else begin
            m_data = ref_wave(int'(mode), m_phase, int'(duty));
            m_sync = m_wrap;
            m_wrap = 1'b0;
            if (enable) begin
                if (m_cnt >= longint'(count_max)) begin
                    m_cnt = 0;
                    m_wrap = (m_phase == 255);
                    m_phase = (m_phase + 1) % 256;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
        check({tag, "_data"}, int'(data), m_data);
        check({tag, "_sync"}, int'(sync), int'(m_sync));
        if (sync === 1'b1) sync_seen++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        // Reset for two cycles.
        rst = 1'b1;
        run("reset", 2);
        check("reset_data_zero", int'(data), 0);
        check("reset_sync_zero", int'(sync), 0);

        // Sawtooth at full rate: first sample 0, syncs 256 cycles apart.
        rst = 1'b0; enable = 1'b1; mode = 2'd1; count_max = 32'd0;
        sync_seen = 0;
        step("saw_first");
        check("saw_first_zero", int'(data), 0);
        run("saw", 599);
        check("saw_sync_count", sync_seen, 2);

        // Pulse with several duty values.
        mode = 2'd0; duty = 8'h80;
        run("pulse80", 300);
        duty = 8'h00;
        run("pulse00", 300);
        duty = 8'hFF;
        run("pulseFF", 300);

        // Triangle.
        mode = 2'd2;
        run("tri", 520);

        // Prescaled sawtooth with a freeze window.
        mode = 2'd1; count_max = 32'd3;
        run("saw_div4", 100);
        enable = 1'b0;
        run("freeze", 10);
        enable = 1'b1;
        run("resume", 100);

        // Lower count_max while the prescaler is far above it.
        count_max = 32'd1000;
        run("cm1000", 500);
        count_max = 32'd10;
        run("cm10", 50);

        // Reset mid-period, then reset coincident with a wrap.
        count_max = 32'd0; mode = 2'd1;
        run("pre_rst", 90);
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        run("post_rst", 300);
        for (int i = 0; i < 300 && m_phase != 255; i++) step("seek_wrap");
        check("seek_wrap_found", m_phase, 255);
        rst = 1'b1;
        step("wrap_rst");
        rst = 1'b0;
        step("after_wrap_rst");
        check("no_sync_after_wrap_rst", int'(sync), 0);
        run("after_wrap_rst2", 20);

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) duty = 8'($urandom);
            if ($urandom_range(0, 63) == 0) count_max = 32'($urandom_range(0, 4));
            enable = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/waveform_oscillator.md
Name: waveform_oscillator

Overview:
Parametrised multi-waveform oscillator and successor to the fixed 8-bit pulse generator. A programmable prescaler advances a DATA_WIDTH-bit phase counter. The phase is mapped to one of three waveforms: pulse with programmable duty, sawtooth or triangle. Feeds the audio/DAC output path and provides a once-per-period sync strobe for downstream blocks such as envelope and sequencer logic.

Parameters:
DATA_WIDTH, 8, sample/phase width in bits (>= 2)
CNT_WIDTH, 32, prescaler counter and count_max width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  1 = prescaler and phase advance; 0 = hold
mode  input  2  0 pulse, 1 sawtooth, 2 triangle, 3 silent
count_max  input  CNT_WIDTH  prescaler terminal value; phase steps every count_max+1 enabled cycles
duty  input  DATA_WIDTH  pulse threshold (mode 0 only)
data  output  DATA_WIDTH  registered waveform sample
sync  output  1  one-cycle strobe, high in the cycle data first shows the phase-0 sample

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst=1 at posedge) clears the following on that edge: prescaler cnt=0, phase=0, data=0, sync=0, internal wrap stage=0. rst has priority over every other input. Asserting rst mid-period restarts cleanly on the next edge; there is no partial state.
- Prescaler, when enable=1:
  - If cnt >= count_max: cnt<=0 and tick=1 (combinational, same cycle).
  - Otherwise: cnt<=cnt+1, tick=0.
  - The >= compare means lowering count_max below the current cnt forces a tick on the next enabled cycle. It must never run to 2^CNT_WIDTH.
  - count_max=0 gives tick every enabled cycle.
- Phase: on tick, phase<=phase+1 modulo 2^DATA_WIDTH (all-ones wraps to 0).
- enable=0: cnt and phase hold. data keeps being recomputed from the held phase, so mode/duty changes remain visible. No sync is generated while disabled.
- Waveform mapping f(phase), registered every cycle: data<=f(phase). data therefore lags phase by 1 cycle.
  - mode 0: all-ones if phase < duty, else 0. duty=0 gives constant 0. duty=2^W-1 gives high for every phase except all-ones.
  - mode 1: phase.
  - mode 2: if phase MSB=0, {phase[W-2:0],0}; else {~phase[W-2:0],0}. For W=8: 0->0, 127->254, 128->254, 255->0. The peak is held for 2 steps and 0 is repeated at the wrap.
  - mode 3: 0.
- Sync:
  - Stage 1: wrap<=tick && phase==all-ones.
  - Stage 2: sync<=wrap.
  - sync is high exactly one cycle, aligned with the first data sample computed from phase 0.
  - With count_max=0, period = 2^DATA_WIDTH cycles between sync pulses.
- Mode change mid-period takes effect on the next data register update (1 cycle). Phase is not reset.
- All arithmetic is unsigned. No outputs are combinational from inputs.

Test Plan:
- W=8, rst 2 cycles, then enable=1, mode=1, count_max=0 -> data =0x00 on first post-reset edge, then +1 per cycle. 0xFF is followed by 0x00 with sync=1 on exactly that 0x00 cycle. Next sync comes 256 cycles later.
- mode=0, duty=0x80, count_max=0 -> 128 cycles data=0xFF, then 128 cycles 0x00, repeating. With duty=0x00, data stays 0x00. With duty=0xFF, data is 0x00 for exactly 1 cycle per period.
- mode=2, count_max=0 -> data sequence 0,2,4,…,254,254,252,…,2,0,0,2…. The samples at phase 127/128 are both 254.
- mode=1, count_max=3 -> data holds each value for 4 cycles. Deasserting enable for 10 cycles freezes data. Re-enable resumes the count with no skipped value.
- count_max=1000, run to cnt≈500, then set count_max=10 -> phase steps on the next cycle, then every 11 cycles.
- Assert rst for 1 cycle mid-period (mode 1, data=0x5A) -> next edge data=0, sync=0. Sequence restarts from 0x00 as in scenario 1. Assert rst coincident with a wrap -> sync is not emitted.
